// File: rtl/fpu_writeback_stage.sv
// Registered writeback stage after the FP ALU: 2-entry result FIFO, sticky flags, compare bit.
// Optional masked-exception trap is built when FPU_WB_TRAP_EN is defined.
module fpu_writeback_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic [5:0]  in_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        cond_flag,
    output logic [5:0]  fflags,
    input  logic        flags_clr,
    input  logic [5:0]  trap_mask,
    input  logic        trap_ack,
    output logic        trap,
    output logic [5:0]  trap_cause
);

    localparam logic [3:0] OP_LAST_ARITH = 4'b1000;
    localparam logic [3:0] OP_LW         = 4'b1001;
    localparam logic [3:0] OP_LUI        = 4'b1011;

    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [4:0]  rd_mem   [2];
    logic [31:0] data_mem [2];

    logic        is_cmp;
    logic        is_enq;
    logic [5:0]  gflags;
    logic        accept;
    logic        push;
    logic        pop;
    logic        trap_hit;
    logic        trap_pending;

    assign is_cmp = (in_op == 4'b0100) || (in_op == 4'b0101) || (in_op == 4'b0110);
    assign is_enq = ((in_op <= OP_LAST_ARITH) && !is_cmp) || (in_op == OP_LW) || (in_op == OP_LUI);
    assign gflags = (in_op <= OP_LAST_ARITH) ? in_flags : 6'b0;

    // in_ready is a function of registered state only, never of in_valid.
    assign in_ready = (count < 2'(DEPTH)) && !trap_pending;
    assign accept   = in_valid && in_ready;
    assign wb_valid = (count != 2'd0);
    assign pop      = wb_valid && wb_ready;
    assign push     = accept && is_enq && !trap_hit;
    assign wb_rd    = rd_mem[rd_ptr];
    assign wb_data  = data_mem[rd_ptr];

    // NOTE: the storage array is reset too, so wb_rd/wb_data read 0 after reset;
    // sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_mem[0]   <= '0;
            rd_mem[1]   <= '0;
            data_mem[0] <= '0;
            data_mem[1] <= '0;
        end else begin
            if (push) begin
                rd_mem[wr_ptr]   <= in_rd;
                data_mem[wr_ptr] <= in_result;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags    <= 6'b0;
            cond_flag <= 1'b0;
        end else begin
            // A clear coinciding with an accept keeps the new op's flags.
            if (flags_clr) begin
                fflags <= accept ? gflags : 6'b0;
            end else if (accept) begin
                fflags <= fflags | gflags;
            end
            if (accept && is_cmp && !trap_hit) begin
                cond_flag <= in_result[0];
            end
        end
    end

`ifdef FPU_WB_TRAP_EN
    logic [5:0] cause_q;

    assign trap_hit   = accept && ((gflags & trap_mask) != 6'b0);
    assign trap       = trap_pending;
    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_pending <= 1'b0;
            cause_q      <= 6'b0;
        end else if (trap_pending && trap_ack) begin
            trap_pending <= 1'b0;
            cause_q      <= 6'b0;
        end else if (trap_hit) begin
            trap_pending <= 1'b1;
            cause_q      <= gflags & trap_mask;
        end
    end
`else
    logic unused_trap_inputs;

    assign trap_hit           = 1'b0;
    assign trap_pending       = 1'b0;
    assign trap               = 1'b0;
    assign trap_cause         = 6'b0;
    assign unused_trap_inputs = ^{trap_mask, trap_ack};
`endif

endmodule

// File: doc/fpu_writeback_stage.md
# fpu_writeback_stage

Registered writeback stage directly downstream of the combinational floating-point ALU. It captures each ALU result together with its six exception flags through a valid/ready handshake and buffers it in a 2-entry FIFO. Entries drain to the FP register-file write port. The block also accumulates sticky exception flags, holds the compare condition bit, and optionally raises a masked exception trap.

## Interface
- `DEPTH`, default 2: FIFO entries. Only the value 2 is supported; pointers are 1 bit.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU output is valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_op`  in  4  ALU control code of the op: 0000 ADD … 1011 LUI.
- `in_rd`  in  5  destination FP register.
- `in_result`  in  32  ALU result.
- `in_flags`  in  6  ALU flags, bit order {div_by_zero, underflow, snan, overflow, qnan, inexact}, bit5 down to bit0.
- `wb_valid`  out  1  head entry is valid.
- `wb_ready`  in  1  register file accepts the write.
- `wb_rd`  out  5  head destination register.
- `wb_data`  out  32  head data.
- `cond_flag`  out  1  last compare result.
- `fflags`  out  6  sticky accumulated flags, same bit order as `in_flags`.
- `flags_clr`  in  1  synchronous clear of `fflags`.
- `trap_mask`  in  6  per-flag trap enable.
- `trap_ack`  in  1  releases a pending trap.
- `trap`  out  1  trap pending.
- `trap_cause`  out  6  masked flags that caused the trap.

## Operation
- **Accept.** An op is accepted when `in_valid && in_ready`.
- **`in_ready`.** `in_ready = (count < 2) && !trap_pending`. It is combinational from registered state only and never depends on `in_valid`.
- **Op classes:**
  - Compare ops (0100, 0101, 0110): `cond_flag <= in_result[0]`. Nothing is enqueued.
  - SW (1010): consumed only. Nothing is enqueued, flags are ignored, `cond_flag` is unchanged.
  - LW (1001) and LUI (1011): enqueued. Flags are ignored.
  - Ops 0000–1000 except compares: enqueued. Flags are accumulated.
  - Codes 1100–1111: consumed, not enqueued, flags ignored.
- **Flag gating.** `gflags = in_flags` for ops 0000–1000, otherwise 0.
- **Sticky flags.**
  - On accept: `fflags <= fflags | gflags`.
  - On `flags_clr`: `fflags <= 0`.
  - `flags_clr` together with an accept: `fflags <= gflags`. The new flags survive the clear.
- **FIFO.**
  - `count` ranges 0..2. Write and read pointers are 1 bit each and wrap 1→0.
  - Pop when `wb_valid && wb_ready`.
  - Push and pop in the same cycle: `count` is unchanged and the data order is preserved.
  - Push is impossible at `count == 2` because `in_ready` is low.
  - `wb_valid = (count != 0)`. `wb_rd` and `wb_data` come from the head entry and stay stable while `wb_valid && !wb_ready`.
- **Trap** (macro enabled only):
  - Trap condition: an accepted op with `(gflags & trap_mask) != 0`.
  - On that cycle: set `trap_pending`, `trap_cause <= gflags & trap_mask`, and still OR `gflags` into `fflags`.
  - The offending op is neither enqueued nor allowed to update `cond_flag`.
  - `trap_pending` forces `in_ready` low.
  - FIFO draining continues normally while a trap is pending.
  - `trap_ack` clears `trap_pending` and `trap_cause` on the next edge. `trap_ack` while no trap is pending has no effect.

## Timing
- **Reset values:**
  - `wb_valid` 0, `wb_rd` 0, `wb_data` 0 (all storage is reset).
  - `fflags` 0, `cond_flag` 0, `trap` 0, `trap_cause` 0, `count` 0, pointers 0.
  - `in_ready` is 1 during reset.
- **Latency.** An op accepted at edge N drives `wb_valid` from edge N, i.e. it is visible in cycle N+1. `fflags` and `cond_flag` update at the same edge N.
- **Throughput.** One op per cycle sustained while `wb_ready` is held high.
- **Backpressure.** With `wb_ready` low, two ops are absorbed, then `in_ready` drops in the cycle after the second accept.
- **Trap timing.** `trap` rises at the edge of the offending accept. `in_ready` is low from the next cycle until the cycle after `trap_ack` is sampled.
- **Reset mid-operation.** `rst_n` low at any time, including with the FIFO full or a trap pending, immediately clears all state. Buffered entries are discarded.

## Configuration
- **`FPU_WB_TRAP_EN` defined:** trap logic as described under Operation.
- **`FPU_WB_TRAP_EN` undefined:**
  - `trap` and `trap_cause` are tied to 0.
  - `trap_mask` and `trap_ack` are ignored.
  - `in_ready = (count < 2)`.
  - Masked ops are enqueued like any other op.

## Test plan
- **Throughput.** ADD, `in_rd` 3, result 0x40400000, flags 0, `wb_ready` 1 → next cycle `wb_valid` 1, `wb_rd` 3, `wb_data` 0x40400000. Back-to-back ops stream at 1 per cycle.
- **Backpressure.** `wb_ready` 0; push results A=0x3F800000, B=0x40000000, then C → `in_ready` drops after B and C is held. Raising `wb_ready` pops A then B, in order.
- **Compare.** C.LT with result 1 → `cond_flag` 1, `wb_valid` stays 0. C.EQ with result 0 → `cond_flag` 0.
- **Sticky flags.**
  - DIV with flags 6'b100000, then ADD with flags 6'b000001 → `fflags` 6'b100001.
  - `flags_clr` in the same cycle as an accept with flags 6'b000100 → `fflags` 6'b000100.
  - SW with flags 6'b111111 → `fflags` unchanged.
- **Trap (enabled).** `trap_mask` 6'b100000; DIV with flags 6'b100000 → `trap` 1, `trap_cause` 6'b100000, op not written back, `in_ready` 0. `trap_ack` → `trap` 0, `in_ready` 1.
- **Reset.** FIFO full and trap pending; pulse `rst_n` low → all outputs at reset values, `in_ready` 1.
